// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: latches one intensity vector, then emits WINDOW steps of spikes.
// Define SPIKE_ENC_DETERMINISTIC_EN to replace the per-channel LFSRs with phase accumulators.
module spike_rate_encoder #(
    parameter int          NUM_INPUTS = 1,
    parameter int          DATA_WIDTH = 8,
    parameter int          WINDOW     = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                             step_en,
    output logic [NUM_INPUTS-1:0]            spike_out,
    output logic                             busy,
    output logic                             window_done
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    typedef enum logic {
        IDLE,
        ENCODE
    } state_e;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 step_cnt_q, step_cnt_d;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] intens_q, intens_d;
    logic [NUM_INPUTS-1:0]            spike_q, spike_d;
    logic [NUM_INPUTS-1:0]            step_spike;
    logic                             done_q, done_d;
    logic                             handshake;
    logic                             do_step;
    logic                             last_step;

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == ENCODE);
    assign spike_out   = spike_q;
    assign window_done = done_q;

    assign handshake = in_valid && in_ready;
    assign do_step   = (state_q == ENCODE) && step_en;
    assign last_step = do_step && (step_cnt_q == CNT_W'(WINDOW - 1));

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        intens_d   = intens_q;
        spike_d    = '0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    intens_d   = in_data;
                    step_cnt_d = '0;
                    state_d    = ENCODE;
                end
            end
            ENCODE: begin
                if (step_en) begin
                    spike_d    = step_spike;
                    step_cnt_d = step_cnt_q + CNT_W'(1);
                    if (last_step) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            intens_q   <= '0;
            spike_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            intens_q   <= intens_d;
            spike_q    <= spike_d;
            done_q     <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] level;
        assign level = intens_q[g*DATA_WIDTH +: DATA_WIDTH];

`ifdef SPIKE_ENC_DETERMINISTIC_EN
        // The carry bit of the accumulator is only ever consumed as the spike, so it lives in spike_q.
        logic [DATA_WIDTH-1:0] acc_q, acc_d;
        logic [DATA_WIDTH:0]   sum;

        assign sum           = {1'b0, acc_q} + {1'b0, level};
        assign step_spike[g] = sum[DATA_WIDTH];

        always_comb begin
            acc_d = acc_q;
            if (handshake) begin
                acc_d = '0;
            end else if (do_step) begin
                acc_d = sum[DATA_WIDTH-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
`else
        localparam logic [15:0] SEED_RAW = LFSR_SEED + 16'(g);
        localparam logic [15:0] SEED     = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

        logic [15:0] lfsr_q, lfsr_d;

        // Fibonacci taps for x^16+x^14+x^13+x^11+1; state survives across windows.
        assign step_spike[g] = (level > lfsr_q[15 -: DATA_WIDTH]);
        assign lfsr_d = do_step ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                                : lfsr_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lfsr_q <= SEED;
            end else begin
                lfsr_q <= lfsr_d;
            end
        end
`endif
    end

endmodule
